md_sched: RTL
=============

# md_sched

Multiply/divide sequencer for the five-stage `mips` pipeline. Accepts `mult`/`multu`/`div`/`divu`/`mthi`/`mtlo` issued from the E stage. Models the fixed multi-cycle latency of the MD unit, owns the HI/LO registers, and raises the stall request that holds any HI/LO-dependent instruction in D until the result is committed.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`; legal range 1..15.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `e_valid` in 1: a valid MD-class operation is in E this cycle.
- `e_op` in 3: 0 `mult`, 1 `multu`, 2 `div`, 3 `divu`, 4 `mthi`, 5 `mtlo`; 6/7 are no-ops.
- `e_rs` in 32: rs operand, forwarded value.
- `e_rt` in 32: rt operand, forwarded value.
- `d_md_use` in 1: the D-stage instruction is `mult`/`multu`/`div`/`divu`/`mthi`/`mtlo`/`mfhi`/`mflo`.
- `busy` out 1: a multiply or divide is in flight.
- `stall_req` out 1: hold D (and freeze PC/F), inject a bubble into E.
- `hi` out 32: current HI register.
- `lo` out 32: current LO register.

## Operation
- States: IDLE and RUN, plus a 4-bit down-counter `cnt` and 64-bit result holding registers `pend_hi`/`pend_lo`.
- **Start condition:** in IDLE with `e_valid` and `e_op` in 0..3.
  - Compute the result from `e_rs`/`e_rt`.
  - Store it in `pend_hi`/`pend_lo`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`, and go to RUN.
- **RUN:**
  - `cnt` decrements each edge.
  - On the edge where `cnt` goes 1→0: copy `pend_hi`→`hi` and `pend_lo`→`lo`, then return to IDLE.
- **Arithmetic:**
  - `mult`: signed 32×32→64. `multu`: unsigned. HI takes bits [63:32], LO takes [31:0].
  - `div`: signed; quotient truncates toward zero; remainder takes the dividend's sign. LO = quotient, HI = remainder.
  - `divu`: unsigned.
  - `div` of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (`e_rt`=0): the operation still occupies RUN for `DIV_CYCLES`, but HI/LO are left unchanged at commit.
- **`mthi`/`mtlo`** in IDLE with `e_valid`: write `e_rs` to HI (or LO) on the next edge. No RUN, no busy.
- **`e_valid` while in RUN:** ignored entirely; no state change. The pipeline prevents this through `stall_req`.
- **Stall equation:** `stall_req = d_md_use & (busy | start)`, where start = IDLE & `e_valid` & `e_op`∈{0..3}. This is combinational.
- `busy` = (state==RUN). It is a registered output.
- **Reset (low), including mid-operation:** state→IDLE, `cnt`=0, `hi`=`lo`=0, pending result discarded.
  - `busy`=0 from the first edge with `reset` low.
  - `stall_req` is 0 while `reset` is low, regardless of the other inputs.

## Timing
- Start accepted at edge T.
  - `busy`=1 for cycles T..T+N-1, where N is the configured cycle count.
  - `hi`/`lo` show the new value, and `busy`=0, after edge T+N.
- `mfhi`/`mflo` in D alongside a start in E: stalled during the start cycle and for all N busy cycles. It is released in the cycle after commit and reads the committed value.
- `mthi`/`mtlo`: visible one cycle after acceptance. A following `mfhi` forwards through the normal E/M path, not through this block.
- Back-to-back MD ops: the second is held in D by `stall_req`. The earliest next start is the cycle after commit.
- No combinational path from `hi`/`lo` to `stall_req`. The only combinational paths are from `e_valid`/`e_op`/`d_md_use` to `stall_req`.

## Test plan
- **Reset:** `reset`=0 for 3 edges → `hi`=`lo`=0, `busy`=0, `stall_req`=0 even with `d_md_use`=1.
- **`mult`:** `e_rs`=0xFFFFFFFE (−2), `e_rt`=3 → `busy` high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Same operands with `multu` → HI=0x00000002, LO=0xFFFFFFFA.
- **`div`:** −7 / 2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - `divu` 7/0 → HI/LO keep their prior values; `busy` lasts 10 cycles.
- **Stall:** `mflo` in D with `div` starting in E → `stall_req`=1 for 11 consecutive cycles (start plus 10 busy), 0 on the 12th.
  - A second `mult` issued as `e_valid` during RUN is ignored: HI/LO match the first op only.
- **`mthi`:** `mthi` 0x12345678 in IDLE → `hi`=0x12345678 next cycle, `busy` stays 0, `lo` unchanged.
- **Reset mid-`div`:** `reset` low at busy cycle 4 of a `div` → `busy`=0 and `hi`=`lo`=0 after that edge, with no later commit.

Source files
------------

// File: rtl/md_sched_if.sv
// Pipeline-side bundle between the E/D stages and the multiply/divide sequencer.
interface md_sched_if;
    logic        e_valid;
    logic [2:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_md_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output e_valid, e_op, e_rs, e_rt, d_md_use,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  e_valid, e_op, e_rs, e_rt, d_md_use,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide sequencer: fixed-latency MD unit model owning HI/LO and the
// D-stage stall request for HI/LO-dependent instructions.
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    md_sched_if.slave   md
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        start_s;
    logic        stall_s;
    logic        res_wr_s;
    logic [63:0] res_s;
    logic [31:0] dvd_s, dvs_s, quo_s, rem_s;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        abs32 = v[31] ? (32'd0 - v) : v;
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        neg_if = neg ? (32'd0 - v) : v;
    endfunction

    // Shared divider operands: signed divide works on magnitudes, zero divisor is masked.
    always_comb begin
        dvd_s = (md.e_op == 3'd2) ? abs32(md.e_rs) : md.e_rs;
        if (md.e_rt == 32'd0) begin
            dvs_s = 32'd1;
        end else begin
            dvs_s = (md.e_op == 3'd2) ? abs32(md.e_rt) : md.e_rt;
        end
        quo_s = dvd_s / dvs_s;
        rem_s = dvd_s % dvs_s;
    end

    // Result of the operation presented in E, plus whether it may be committed.
    always_comb begin
        res_s    = 64'd0;
        res_wr_s = 1'b1;
        case (md.e_op)
            3'd0: res_s = {{32{md.e_rs[31]}}, md.e_rs} * {{32{md.e_rt[31]}}, md.e_rt};
            3'd1: res_s = {32'd0, md.e_rs} * {32'd0, md.e_rt};
            3'd2: begin
                // Quotient sign from operand signs, remainder follows the dividend.
                res_s    = {neg_if(rem_s, md.e_rs[31]),
                            neg_if(quo_s, md.e_rs[31] ^ md.e_rt[31])};
                res_wr_s = (md.e_rt != 32'd0);
            end
            3'd3: begin
                res_s    = {rem_s, quo_s};
                res_wr_s = (md.e_rt != 32'd0);
            end
            default: begin
                res_s    = 64'd0;
                res_wr_s = 1'b0;
            end
        endcase
    end

    // Start detection and combinational stall request.
    always_comb begin
        start_s = (state_q == ST_IDLE) & md.e_valid & ~md.e_op[2];
        stall_s = reset & md.d_md_use & ((state_q == ST_RUN) | start_s);
    end

    // Sequencer next state: accept in IDLE, count down in RUN, commit on the last edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (state_q == ST_IDLE) begin
            if (start_s) begin
                state_d   = ST_RUN;
                cnt_d     = md.e_op[1] ? DIV_CNT : MULT_CNT;
                pend_hi_d = res_s[63:32];
                pend_lo_d = res_s[31:0];
                pend_wr_d = res_wr_s;
            end else if (md.e_valid && (md.e_op == 3'd4)) begin
                hi_d = md.e_rs;
            end else if (md.e_valid && (md.e_op == 3'd5)) begin
                lo_d = md.e_rs;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                if (pend_wr_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end else begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign md.busy      = (state_q == ST_RUN);
    assign md.stall_req = stall_s;
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;

endmodule
